// File: rtl/simon_pkg.sv
// Shared state type, note encodings and level table for the note-memory game.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        PLAY,
        LISTEN,
        PASS,
        FAIL,
        DONE
    } simon_state_e;

    localparam logic [3:0] NOTE_0 = 4'h1;
    localparam logic [3:0] NOTE_1 = 4'h2;
    localparam logic [3:0] NOTE_2 = 4'h4;
    localparam logic [3:0] NOTE_3 = 4'h8;

    // First note of each level sits in the top nibble; unused nibbles are zero.
    localparam logic [15:0] L0_DATA = 16'h1200;
    localparam logic [3:0]  L0_LEN  = 4'd2;
    localparam logic [15:0] L1_DATA = 16'h4180;
    localparam logic [3:0]  L1_LEN  = 4'd3;
    localparam logic [15:0] L2_DATA = 16'h2841;
    localparam logic [3:0]  L2_LEN  = 4'd4;
    localparam logic [15:0] L3_DATA = 16'h8124;
    localparam logic [3:0]  L3_LEN  = 4'd4;

endpackage

// File: rtl/simon_level_rom.sv
// Combinational level table lookup; indices beyond the table fall back to level 0.
module simon_level_rom
    import simon_pkg::*;
(
    input  logic [2:0]  index,
    output logic [15:0] data,
    output logic [3:0]  length
);

    always_comb begin
        data   = L0_DATA;
        length = L0_LEN;
        case (index)
            3'd1: begin
                data   = L1_DATA;
                length = L1_LEN;
            end
            3'd2: begin
                data   = L2_DATA;
                length = L2_LEN;
            end
            3'd3: begin
                data   = L3_DATA;
                length = L3_LEN;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/simon_round_controller.sv
// Level sequencer for the note-memory game: load, play back, listen, score.
// Define SIMON_INPUT_TIMEOUT_EN to fail the game when the player stalls in LISTEN.
module simon_round_controller
    import simon_pkg::*;
#(
    parameter int          NUM_LEVELS     = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_game,
    input  logic         key_valid,
    input  logic [3:0]   key_note,
    input  logic         done_playback,
    output logic         load_level,
    output logic         start_playback,
    output logic [15:0]  level_data,
    output logic [3:0]   level_length,
    output logic [2:0]   level_index,
    output logic [3:0]   score,
    output logic         listening,
    output logic         win,
    output logic         game_over,
    output logic         timed_out,
    output simon_state_e dbg_state
);

    simon_state_e state_q, state_d;
    logic [2:0]   level_index_q, level_index_d;
    logic [3:0]   score_q, score_d;
    logic         win_q, win_d;
    logic         game_over_q, game_over_d;
    logic         timed_out_q, timed_out_d;
    logic         load_level_q, load_level_d;
    logic         start_playback_q, start_playback_d;
    logic         listening_q, listening_d;
    logic [15:0]  level_data_q, level_data_d;
    logic [3:0]   level_length_q, level_length_d;
    logic [15:0]  exp_q, exp_d;
    logic [3:0]   remaining_q, remaining_d;
    logic [2:0]   rom_index;
    logic [15:0]  rom_data;
    logic [3:0]   rom_length;
`ifdef SIMON_INPUT_TIMEOUT_EN
    logic [31:0]  tmo_q, tmo_d;
`else
    logic         unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // LOAD is entered either fresh (level 0) or from PASS (next level).
    always_comb begin
        rom_index = level_index_q + 3'd1;
        if (state_q == IDLE || state_q == DONE) rom_index = 3'd0;
    end

    simon_level_rom u_rom (
        .index  (rom_index),
        .data   (rom_data),
        .length (rom_length)
    );

    always_comb begin
        state_d        = state_q;
        level_index_d  = level_index_q;
        score_d        = score_q;
        win_d          = win_q;
        game_over_d    = game_over_q;
        timed_out_d    = timed_out_q;
        level_data_d   = level_data_q;
        level_length_d = level_length_q;
        exp_d          = exp_q;
        remaining_d    = remaining_q;
`ifdef SIMON_INPUT_TIMEOUT_EN
        tmo_d          = tmo_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_game) begin
                    state_d       = LOAD;
                    level_index_d = 3'd0;
                    score_d       = 4'd0;
                    win_d         = 1'b0;
                    game_over_d   = 1'b0;
                    timed_out_d   = 1'b0;
                end
            end
            LOAD: state_d = ARM;
            ARM:  state_d = PLAY;
            PLAY: begin
                if (done_playback) begin
                    state_d = LISTEN;
`ifdef SIMON_INPUT_TIMEOUT_EN
                    tmo_d   = TIMEOUT_CYCLES - 32'd1;
`endif
                end
            end
            LISTEN: begin
                // A key arriving on the expiry cycle takes priority over the timeout.
                if (key_valid) begin
                    if (key_note == exp_q[15:12]) begin
                        exp_d       = {exp_q[11:0], 4'h0};
                        remaining_d = remaining_q - 4'd1;
                        if (remaining_q == 4'd1) state_d = PASS;
`ifdef SIMON_INPUT_TIMEOUT_EN
                        tmo_d       = TIMEOUT_CYCLES - 32'd1;
`endif
                    end else begin
                        state_d     = FAIL;
                        game_over_d = 1'b1;
                    end
                end
`ifdef SIMON_INPUT_TIMEOUT_EN
                else if (tmo_q == 32'd0) begin
                    state_d     = FAIL;
                    game_over_d = 1'b1;
                    timed_out_d = 1'b1;
                end else begin
                    tmo_d = tmo_q - 32'd1;
                end
`endif
            end
            PASS: begin
                if (score_q != 4'd15) score_d = score_q + 4'd1;
                if (level_index_q == 3'(NUM_LEVELS - 1)) begin
                    state_d = DONE;
                    win_d   = 1'b1;
                end else begin
                    state_d       = LOAD;
                    level_index_d = level_index_q + 3'd1;
                end
            end
            FAIL:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (state_d == LOAD) begin
            level_data_d   = rom_data;
            level_length_d = rom_length;
            exp_d          = rom_data;
            remaining_d    = rom_length;
        end

        load_level_d     = (state_d == LOAD);
        start_playback_d = (state_d == PLAY);
        listening_d      = (state_d == LISTEN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            level_index_q    <= 3'd0;
            score_q          <= 4'd0;
            win_q            <= 1'b0;
            game_over_q      <= 1'b0;
            timed_out_q      <= 1'b0;
            load_level_q     <= 1'b0;
            start_playback_q <= 1'b0;
            listening_q      <= 1'b0;
            level_data_q     <= 16'h0000;
            level_length_q   <= 4'd0;
            exp_q            <= 16'h0000;
            remaining_q      <= 4'd0;
`ifdef SIMON_INPUT_TIMEOUT_EN
            tmo_q            <= 32'd0;
`endif
        end else begin
            state_q          <= state_d;
            level_index_q    <= level_index_d;
            score_q          <= score_d;
            win_q            <= win_d;
            game_over_q      <= game_over_d;
            timed_out_q      <= timed_out_d;
            load_level_q     <= load_level_d;
            start_playback_q <= start_playback_d;
            listening_q      <= listening_d;
            level_data_q     <= level_data_d;
            level_length_q   <= level_length_d;
            exp_q            <= exp_d;
            remaining_q      <= remaining_d;
`ifdef SIMON_INPUT_TIMEOUT_EN
            tmo_q            <= tmo_d;
`endif
        end
    end

    assign load_level     = load_level_q;
    assign start_playback = start_playback_q;
    assign level_data     = level_data_q;
    assign level_length   = level_length_q;
    assign level_index    = level_index_q;
    assign score          = score_q;
    assign listening      = listening_q;
    assign win            = win_q;
    assign game_over      = game_over_q;
`ifdef SIMON_INPUT_TIMEOUT_EN
    assign timed_out      = timed_out_q;
`else
    assign timed_out      = 1'b0;
`endif
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_simon_round_controller.sv
// Randomized game-level bench for simon_round_controller against a note-list model.
// Timeout scenario runs only when SIMON_INPUT_TIMEOUT_EN is defined.
module tb_simon_round_controller;
    import simon_pkg::*;

    localparam int NUM_LEVELS = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start_game;
    logic         key_valid;
    logic [3:0]   key_note;
    logic         done_playback;
    logic         load_level;
    logic         start_playback;
    logic [15:0]  level_data;
    logic [3:0]   level_length;
    logic [2:0]   level_index;
    logic [3:0]   score;
    logic         listening;
    logic         win;
    logic         game_over;
    logic         timed_out;
    simon_state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each level is a list of notes; score counts levels cleared.
    logic [3:0] lv_note [4][4];
    int         lv_len  [4];
    int         m_score;

    simon_round_controller #(
        .NUM_LEVELS     (NUM_LEVELS),
        .TIMEOUT_CYCLES (32'd8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start_game     (start_game),
        .key_valid      (key_valid),
        .key_note       (key_note),
        .done_playback  (done_playback),
        .load_level     (load_level),
        .start_playback (start_playback),
        .level_data     (level_data),
        .level_length   (level_length),
        .level_index    (level_index),
        .score          (score),
        .listening      (listening),
        .win            (win),
        .game_over      (game_over),
        .timed_out      (timed_out),
        .dbg_state      (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [15:0] exp_data(input int lvl);
        logic [15:0] d = 16'h0000;
        for (int i = 0; i < lv_len[lvl]; i++) d[15-4*i -: 4] = lv_note[lvl][i];
        return d;
    endfunction

    task automatic press(input logic [3:0] note);
        key_valid = 1'b1;
        key_note  = note;
        tick();
        key_valid = 1'b0;
        key_note  = 4'($urandom_range(15));
    endtask

    // Entered on the cycle load_level is expected; leaves the DUT in LISTEN.
    task automatic run_playback(input int lvl);
        check("load_level_high", 32'(load_level), 32'd1);
        check("level_data", 32'(level_data), 32'(exp_data(lvl)));
        check("level_length", 32'(level_length), 32'(lv_len[lvl]));
        check("level_index", 32'(level_index), 32'(lvl));
        check("score_at_load", 32'(score), 32'(m_score));
        check("game_over_at_load", 32'(game_over), 32'd0);
        done_playback = 1'b0;
        tick();
        check("load_level_one_cycle", 32'(load_level), 32'd0);
        check("no_early_playback", 32'(start_playback), 32'd0);
        tick();
        check("start_playback_rise", 32'(start_playback), 32'd1);
        key_valid = 1'b1;
        key_note  = 4'($urandom_range(15));
        tick();
        key_valid = 1'b0;
        tick();
        check("playback_running", 32'(start_playback), 32'd1);
        done_playback = 1'b1;
        tick();
        check("start_playback_fall", 32'(start_playback), 32'd0);
        check("listening_entry", 32'(listening), 32'd1);
        check("state_listen", 32'(dbg_state), 32'(LISTEN));
    endtask

    // Plays one game; f_* force one wrong key, stop_lvl aborts after the first key of that level.
    task automatic play_game(input int err_pct, input int f_lvl, input int f_pos,
                             input logic [3:0] f_key, input int stop_lvl);
        bit         lost = 1'b0;
        bit         wrong;
        logic [3:0] k;
        m_score    = 0;
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        for (int lvl = 0; lvl < NUM_LEVELS && !lost; lvl++) begin
            run_playback(lvl);
            for (int pos = 0; pos < lv_len[lvl] && !lost; pos++) begin
                k     = lv_note[lvl][pos];
                wrong = ($urandom_range(99) < err_pct);
                if (wrong) begin
                    do k = 4'($urandom_range(15)); while (k == lv_note[lvl][pos]);
                end
                if (lvl == f_lvl && pos == f_pos) begin
                    k     = f_key;
                    wrong = (f_key != lv_note[lvl][pos]);
                end
                press(k);
                if (wrong) begin
                    check("state_fail", 32'(dbg_state), 32'(FAIL));
                    lost = 1'b1;
                end else if (lvl == stop_lvl) begin
                    check("key_accepted", 32'(dbg_state), 32'(LISTEN));
                    return;
                end else if (pos == lv_len[lvl] - 1) begin
                    check("state_pass", 32'(dbg_state), 32'(PASS));
                end else begin
                    check("still_listening", 32'(listening), 32'd1);
                    repeat ($urandom_range(3)) tick();
                end
            end
            if (!lost) begin
                m_score++;
                tick();
                if (lvl == NUM_LEVELS - 1) begin
                    check("state_done_win", 32'(dbg_state), 32'(DONE));
                    check("win", 32'(win), 32'd1);
                    check("score_win", 32'(score), 32'(m_score));
                    check("level_index_win", 32'(level_index), 32'(NUM_LEVELS - 1));
                    check("game_over_win", 32'(game_over), 32'd0);
                end
            end
        end
        if (lost) begin
            tick();
            check("state_done_loss", 32'(dbg_state), 32'(DONE));
            check("game_over", 32'(game_over), 32'd1);
            check("win_loss", 32'(win), 32'd0);
            check("score_loss", 32'(score), 32'(m_score));
            check("timed_out_wrong_note", 32'(timed_out), 32'd0);
        end
        tick();
        check("done_holds", 32'(dbg_state), 32'(DONE));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_load_level"}, 32'(load_level), 32'd0);
        check({tag, "_start_playback"}, 32'(start_playback), 32'd0);
        check({tag, "_listening"}, 32'(listening), 32'd0);
        check({tag, "_win"}, 32'(win), 32'd0);
        check({tag, "_game_over"}, 32'(game_over), 32'd0);
        check({tag, "_timed_out"}, 32'(timed_out), 32'd0);
        check({tag, "_level_data"}, 32'(level_data), 32'h0);
        check({tag, "_level_length"}, 32'(level_length), 32'd0);
        check({tag, "_level_index"}, 32'(level_index), 32'd0);
        check({tag, "_score"}, 32'(score), 32'd0);
    endtask

    initial begin
        lv_note[0] = '{NOTE_0, NOTE_1, 4'h0, 4'h0};  lv_len[0] = 2;
        lv_note[1] = '{NOTE_2, NOTE_0, NOTE_3, 4'h0}; lv_len[1] = 3;
        lv_note[2] = '{NOTE_1, NOTE_3, NOTE_2, NOTE_0}; lv_len[2] = 4;
        lv_note[3] = '{NOTE_3, NOTE_0, NOTE_1, NOTE_2}; lv_len[3] = 4;

        reset         = 1'b1;
        start_game    = 1'b0;
        key_valid     = 1'b0;
        key_note      = 4'h0;
        done_playback = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();
        check("idle_after_reset", 32'(dbg_state), 32'(IDLE));

        // Full-game win with the table's own notes.
        play_game(0, -1, -1, 4'h0, -1);

        // Wrong second note in level 0, then a restart from DONE.
        play_game(0, 0, 1, NOTE_2, -1);
        play_game(0, -1, -1, 4'h0, -1);

        // Asynchronous reset in the middle of level 2.
        play_game(0, -1, -1, 4'h0, 2);
        #2 reset = 1'b1;
        #1 check_reset_values("mid_reset");
        tick();
        reset = 1'b0;
        tick();
        check("idle_after_mid_reset", 32'(dbg_state), 32'(IDLE));

`ifdef SIMON_INPUT_TIMEOUT_EN
        m_score    = 0;
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
        run_playback(0);
        repeat (7) tick();
        check("tmo_still_listening", 32'(dbg_state), 32'(LISTEN));
        press(NOTE_0);
        check("tmo_last_cycle_key", 32'(dbg_state), 32'(LISTEN));
        repeat (7) tick();
        check("tmo_reloaded", 32'(dbg_state), 32'(LISTEN));
        tick();
        check("tmo_fail", 32'(dbg_state), 32'(FAIL));
        tick();
        check("tmo_done", 32'(dbg_state), 32'(DONE));
        check("tmo_timed_out", 32'(timed_out), 32'd1);
        check("tmo_game_over", 32'(game_over), 32'd1);
`endif

        for (int g = 0; g < 30; g++) play_game(8, -1, -1, 4'h0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simon_round_controller.md
# simon_round_controller

Top-level sequencer for the note-memory game. It walks the player through a fixed table of levels. For each level it loads the level into the playback block, runs playback to completion, then collects and checks the player's key presses against the same note sequence. It keeps the level index and score, and ends the game on a win, a wrong note or (optionally) an input timeout.

## Interface
- `NUM_LEVELS`, default 4: levels in the table, 1..8.
- `TIMEOUT_CYCLES`, default 32'd250_000_000: cycles allowed between player keys. Used only when the timeout feature is compiled in.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clock `clock`.
- `start_game` in 1: start or restart request; level-sensitive, sampled each cycle.
- `key_valid` in 1: single-cycle pulse, one player key press.
- `key_note` in 4: one-hot note of the key; valid when `key_valid` is high.
- `done_playback` in 1: from playback; high when its note counter is zero.
- `load_level` out 1: one-cycle load strobe to playback.
- `start_playback` out 1: playback run enable.
- `level_data` out 16: up to four notes, first note in [15:12].
- `level_length` out 4: notes in the level, 1..4.
- `level_index` out 3: current level, 0-based.
- `score` out 4: levels completed in this game.
- `listening` out 1: high while player input is accepted.
- `win` out 1: sticky; all levels passed.
- `game_over` out 1: sticky; game lost.
- `timed_out` out 1: sticky; the loss was a timeout.

## Operation
- States: IDLE, LOAD, ARM, PLAY, LISTEN, PASS, FAIL, DONE. Outputs are Moore decodes of the registered state plus datapath registers.
- IDLE:
  - `start_game`=1 → LOAD.
  - On that transition `level_index`, `score`, `win`, `game_over` and `timed_out` clear.
- LOAD:
  - `load_level`=1 for exactly this cycle.
  - `level_data` and `level_length` are driven from the level table at `level_index`.
  - The expected-note shift register `exp` is loaded with the data and `remaining` is loaded with the length.
  - → ARM.
- ARM: one settle cycle so `done_playback` reflects the new counter value. → PLAY.
- PLAY:
  - `start_playback`=1.
  - `done_playback`=1 → LISTEN, and `start_playback` drops on the same edge.
- LISTEN:
  - `listening`=1.
  - On `key_valid` with `key_note`==`exp[15:12]`: `exp` shifts left 4 and `remaining` decrements. If `remaining` was 1 → PASS.
  - On `key_valid` with a mismatch → FAIL.
  - `key_valid` is ignored in every other state.
- PASS:
  - `score` increments; it saturates at 15.
  - If `level_index`==`NUM_LEVELS`-1 → DONE with `win`=1.
  - Otherwise `level_index` increments → LOAD.
- FAIL: `game_over`=1 → DONE.
- DONE: outputs hold. `start_game`=1 → LOAD with the same clears as IDLE.
- `start_game` is ignored in LOAD, ARM, PLAY, LISTEN, PASS and FAIL.
- `key_note` with zero bits or multiple bits set never matches a table entry, so it counts as a mismatch.

## Timing
- Reset values:
  - State = IDLE.
  - `load_level`, `start_playback`, `listening`, `win`, `game_over`, `timed_out` = 0.
  - `level_data`=16'h0000, `level_length`=0, `level_index`=0, `score`=0.
- Reset asserted mid-game aborts immediately to IDLE with the values above. No partial state survives.
- Latency from `start_game` to `load_level`: 1 cycle. `load_level` to `start_playback`: 2 cycles.
- A matching final key reaches PASS on the next edge. The next level's `load_level` follows 1 cycle later.
- The last key accepted in LISTEN and a timeout expiring on the same cycle: the key wins.

## Configuration
- `SIMON_INPUT_TIMEOUT_EN` defined:
  - A 32-bit down-counter loads `TIMEOUT_CYCLES`-1 on entry to LISTEN and after each accepted key.
  - When it reaches 0 with no key → FAIL, and `game_over` and `timed_out` are set.
- Macro undefined:
  - No counter is built.
  - `timed_out` is tied to 0.
  - LISTEN waits indefinitely.

## Structure
- Package `simon_pkg` holds:
  - The state enum.
  - The note one-hot constants NOTE_0..NOTE_3 = 4'h1, 4'h2, 4'h4, 4'h8.
  - The level table: L0=16'h1200/len2, L1=16'h4180/len3, L2=16'h2841/len4, L3=16'h8124/len4.
- One sub-module, `simon_level_rom`: a combinational index→{data,length} lookup. Out-of-range indices return the L0 entry.

## Test plan
- Full-game win:
  - Stimulus: `start_game`; model `done_playback` 3 cycles after `start_playback`; keys 1,2 / 4,1,8 / 2,8,4,1 / 8,1,2,4.
  - Required response: `win`=1, `score`=4, `level_index`=3, DONE.
- Wrong note:
  - Stimulus: in level 0 press 1 then 4.
  - Required response: FAIL then DONE, `game_over`=1, `score`=0, `win`=0.
- Handshake timing:
  - `load_level` is high exactly 1 cycle.
  - `start_playback` rises 2 cycles after `load_level` and falls on the edge after `done_playback`=1.
  - A `key_valid` during PLAY is ignored.
- Reset mid-LISTEN:
  - Stimulus: assert `reset` at level 2, press 1 accepted.
  - Required response: all outputs return to their reset values asynchronously; state is IDLE.
- Restart from DONE:
  - Stimulus: `start_game` after a loss.
  - Required response: `score`, `level_index`, `game_over` clear; `level_data`=16'h1200 with `load_level`.
- Timeout (`SIMON_INPUT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):
  - No key for 8 cycles in LISTEN → `timed_out`=1, `game_over`=1.
  - A key at cycle 7 → the counter reloads and there is no failure.
